// File: rtl/sram_arb.sv
// sram_arb - single-port SRAM controller and two-way arbiter (clk_100m domain)
//
// Shares one asynchronous SRAM between the PPU core (render fetch) and the
// CPU interface. The core has priority; the CPU is served whenever the core
// is not requesting at an arbitration point. All SRAM strobes, the pad
// output enable and every requester-facing pulse are registered.
//
// Optional feature (compile-time macro SRAM_ARB_STARVE_GUARD_EN):
//   a burst counter lets the CPU win after MAX_BURST back-to-back core
//   grants taken while the CPU was waiting. Undefined = strict core priority.
//
// Ports:
//   clk_100m, rst                   clock, async active-high reset
//   core_req/we/addr/wdata          core request (level, hold until core_gnt)
//   core_gnt, core_rvalid           one-cycle pulses
//   core_rdata                      last core read data, held
//   cpu_req/we/addr/wdata           CPU request, same rules as core
//   cpu_gnt, cpu_rvalid, cpu_rdata  CPU grant / read return
//   sram_addr, sram_dq_o            registered address / write data to pad
//   sram_dq_oe                      pad output enable (high only in WR)
//   sram_dq_i                       read data from pad
//   sram_ce_n/oe_n/we_n             SRAM strobes, active low
//   busy                            FSM not in IDLE
module sram_arb #(
  parameter int AW        = 18,
  parameter int DW        = 16,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 8
) (
  input  logic          clk_100m,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    TURN = 2'd3
  } state_t;

  // The read counter counts down to zero, so it is loaded with RD_LAT-1 to
  // keep oe_n low for exactly RD_LAT cycles.
  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);

  state_t        state;
  logic [3:0]    rd_cnt;
  logic          owner_cpu;
  logic          cpu_forced;
  logic          pick_core;
  logic          pick_cpu;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  // Counts core grants taken while the CPU is kept waiting; any CPU grant or
  // the CPU letting go of its request starts the count over.
  logic [7:0] starve_cnt;

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pick_cpu || !cpu_req) begin
      starve_cnt <= '0;
    end else if (pick_core) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  assign cpu_forced = (starve_cnt == 8'(MAX_BURST));
`else
  assign cpu_forced = 1'b0;
`endif

  // Arbitration is only meaningful in IDLE; the core wins ties unless the
  // starvation guard has tripped.
  always_comb begin
    pick_core = 1'b0;
    pick_cpu  = 1'b0;
    if (state == IDLE) begin
      if (cpu_req && (!core_req || cpu_forced)) begin
        pick_cpu = 1'b1;
      end else if (core_req) begin
        pick_core = 1'b1;
      end
    end
    sel_we    = pick_cpu ? cpu_we    : core_we;
    sel_addr  = pick_cpu ? cpu_addr  : core_addr;
    sel_wdata = pick_cpu ? cpu_wdata : core_wdata;
  end

  // Access sequencer. Strobes are set on the transition into each state so
  // they are glitch-free register outputs; the read data is sampled at the
  // same edge that drops oe_n.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      owner_cpu   <= 1'b0;
      core_gnt    <= 1'b0;
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      cpu_gnt     <= 1'b0;
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      sram_addr   <= '0;
      sram_dq_o   <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      core_gnt    <= 1'b0;
      cpu_gnt     <= 1'b0;
      core_rvalid <= 1'b0;
      cpu_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_core || pick_cpu) begin
            owner_cpu <= pick_cpu;
            core_gnt  <= pick_core;
            cpu_gnt   <= pick_cpu;
            sram_addr <= sel_addr;
            sram_dq_o <= sel_wdata;
            sram_ce_n <= 1'b0;
            busy      <= 1'b1;
            if (sel_we) begin
              state      <= WR;
              sram_we_n  <= 1'b0;
              sram_dq_oe <= 1'b1;
            end else begin
              state     <= RD;
              sram_oe_n <= 1'b0;
              rd_cnt    <= RD_LOAD;
            end
          end
        end
        RD: begin
          if (rd_cnt == 4'd0) begin
            if (owner_cpu) begin
              cpu_rdata  <= sram_dq_i;
              cpu_rvalid <= 1'b1;
            end else begin
              core_rdata  <= sram_dq_i;
              core_rvalid <= 1'b1;
            end
            state     <= IDLE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            busy      <= 1'b0;
          end else begin
            rd_cnt <= rd_cnt - 4'd1;
          end
        end
        WR: begin
          // Release the bus for one dead cycle so the pad driver is off
          // before the SRAM can drive a following read.
          state      <= TURN;
          sram_ce_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
        TURN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
